// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the decode stage: opcode values, FSM encoding
// and the sign-extension helper used when forming immediate/offset fields.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-extend the low 'width' bits of val to 16 bits (width in 1..15).
  function automatic logic [15:0] sext(input logic [15:0] val, input logic [3:0] width);
    logic [15:0] mask;
    mask = 16'hFFFF << width;
    return val[width - 4'd1] ? (val | mask) : (val & ~mask);
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch <-> decode bundle: start/flush handshake, PC and instruction word in,
// decoded fields and status out.
interface decode_if;
  logic        decode_start;
  logic [15:0] pc_in;
  logic [15:0] instr_in;
  logic        flush;

  logic [15:0] ir_out;
  logic [15:0] npc_out;
  logic [3:0]  opCode_out;
  logic [2:0]  dr_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic        imm_sel_out;
  logic [15:0] imm5_out;
  logic [15:0] offset6_out;
  logic [8:0]  offset9_out;
  logic [2:0]  br_nzp_out;
  logic        reg_write_out;
  logic        mem_op_out;
  logic        illegal_out;
  logic        busy;
  logic        decode_done;

  modport master (
    output decode_start, pc_in, instr_in, flush,
    input  ir_out, npc_out, opCode_out, dr_out, sr1_out, sr2_out, imm_sel_out,
           imm5_out, offset6_out, offset9_out, br_nzp_out, reg_write_out,
           mem_op_out, illegal_out, busy, decode_done
  );

  modport slave (
    input  decode_start, pc_in, instr_in, flush,
    output ir_out, npc_out, opCode_out, dr_out, sr1_out, sr2_out, imm_sel_out,
           imm5_out, offset6_out, offset9_out, br_nzp_out, reg_write_out,
           mem_op_out, illegal_out, busy, decode_done
  );
endinterface

// File: rtl/decode_ctrl.sv
// Combinational LC-3 opcode decoder: register specifiers, branch condition
// and control flags derived from a raw instruction word.
module decode_ctrl
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [2:0]  br_nzp,
  output logic        imm_sel,
  output logic        reg_write,
  output logic        mem_op,
  output logic        illegal
);

  always_comb begin
    dr        = 3'd0;
    sr1       = 3'd0;
    sr2       = 3'd0;
    br_nzp    = 3'd0;
    imm_sel   = 1'b0;
    reg_write = 1'b0;
    mem_op    = 1'b0;
    illegal   = 1'b0;
    case (ir[15:12])
      OP_ADD, OP_AND: begin
        dr        = ir[11:9];
        sr1       = ir[8:6];
        sr2       = ir[2:0];
        imm_sel   = ir[5];
        reg_write = 1'b1;
      end
      OP_NOT: begin
        dr        = ir[11:9];
        sr1       = ir[8:6];
        reg_write = 1'b1;
      end
      OP_BR:  br_nzp = ir[11:9];
      OP_LD, OP_LDI: begin
        dr        = ir[11:9];
        reg_write = 1'b1;
        mem_op    = 1'b1;
      end
      OP_LEA: begin
        dr        = ir[11:9];
        reg_write = 1'b1;
      end
      // Stores carry the data register in the DR slot; route it to sr2.
      OP_ST, OP_STI: begin
        sr2    = ir[11:9];
        mem_op = 1'b1;
      end
      OP_LDR: begin
        dr        = ir[11:9];
        sr1       = ir[8:6];
        reg_write = 1'b1;
        mem_op    = 1'b1;
      end
      OP_STR: begin
        sr1    = ir[8:6];
        sr2    = ir[11:9];
        mem_op = 1'b1;
      end
      OP_JMP: sr1 = ir[8:6];
      // JSR links through R7; only the register form (JSRR) reads a base.
      OP_JSR: begin
        dr        = 3'd7;
        reg_write = 1'b1;
        if (!ir[11]) sr1 = ir[8:6];
      end
      OP_TRAP: begin
        dr        = 3'd7;
        reg_write = 1'b1;
        mem_op    = 1'b1;
      end
      OP_RTI, OP_RES: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: waits out instruction-memory latency after a start
// pulse, captures the returned word into IR and registers the decoded fields.
module decode
  import lc3_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture;

  logic [15:0] pc_p0;
  logic [15:0] ir_p1, npc_p1;
  logic [2:0]  dr_p1, sr1_p1, sr2_p1, nzp_p1;
  logic        imm_sel_p1, reg_write_p1, mem_op_p1, illegal_p1;

  logic [2:0]  dr_c, sr1_c, sr2_c, nzp_c;
  logic        imm_sel_c, reg_write_c, mem_op_c, illegal_c;

  decode_ctrl u_ctrl (
    .ir        (bus.instr_in),
    .dr        (dr_c),
    .sr1       (sr1_c),
    .sr2       (sr2_c),
    .br_nzp    (nzp_c),
    .imm_sel   (imm_sel_c),
    .reg_write (reg_write_c),
    .mem_op    (mem_op_c),
    .illegal   (illegal_c)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (bus.decode_start && !bus.flush) begin
        accept    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.decode_start && !bus.flush) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == ST_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Stage p0: PC held privately so npc_out only moves at the capture edge.
  always_ff @(posedge clk) begin
    if (rst)
      pc_p0 <= '0;
    else if (accept)
      pc_p0 <= bus.pc_in;
  end

  // Stage p1: architectural decode outputs, updated at capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p1        <= '0;
      npc_p1       <= '0;
      dr_p1        <= '0;
      sr1_p1       <= '0;
      sr2_p1       <= '0;
      nzp_p1       <= '0;
      imm_sel_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_op_p1    <= 1'b0;
      illegal_p1   <= 1'b0;
    end else if (capture) begin
      ir_p1        <= bus.instr_in;
      npc_p1       <= pc_p0;
      dr_p1        <= dr_c;
      sr1_p1       <= sr1_c;
      sr2_p1       <= sr2_c;
      nzp_p1       <= nzp_c;
      imm_sel_p1   <= imm_sel_c;
      reg_write_p1 <= reg_write_c;
      mem_op_p1    <= mem_op_c;
      illegal_p1   <= illegal_c;
    end
  end

  assign bus.ir_out        = ir_p1;
  assign bus.npc_out       = npc_p1;
  assign bus.opCode_out    = ir_p1[15:12];
  assign bus.dr_out        = dr_p1;
  assign bus.sr1_out       = sr1_p1;
  assign bus.sr2_out       = sr2_p1;
  assign bus.imm_sel_out   = imm_sel_p1;
  assign bus.imm5_out      = sext(ir_p1, 4'd5);
  assign bus.offset6_out   = sext(ir_p1, 4'd6);
  assign bus.offset9_out   = ir_p1[8:0];
  assign bus.br_nzp_out    = nzp_p1;
  assign bus.reg_write_out = reg_write_p1;
  assign bus.mem_op_out    = mem_op_p1;
  assign bus.illegal_out   = illegal_p1;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.decode_done   = (state == ST_DONE);

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the LC-3 decode stage: fixed vector table, hand
// sequences for handshake corner cases, and randomized words vs. a model.
module tb_decode;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_sel;
    logic [15:0] imm5;
    logic [15:0] off6;
    logic [8:0]  off9;
    logic [2:0]  nzp;
    logic        rw;
    logic        mo;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    dec_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if i1 ();
  decode_if i3 ();

  decode #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  decode #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(i3));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name, input dec_t act, input dec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Two's-complement value of an unsigned 'bits'-wide field.
  function automatic int sx(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic dec_t model(input logic [15:0] ir, input logic [15:0] pc);
    dec_t m;
    int opc, a, b, c;
    opc = int'(ir[15:12]);
    a   = int'(ir[11:9]);
    b   = int'(ir[8:6]);
    c   = int'(ir[2:0]);
    m      = '0;
    m.ir   = ir;
    m.npc  = pc;
    m.op   = ir[15:12];
    m.imm5 = 16'(sx(int'(ir[4:0]), 5));
    m.off6 = 16'(sx(int'(ir[5:0]), 6));
    m.off9 = ir[8:0];
    case (opc)
      1, 5:  begin m.dr = 3'(a); m.sr1 = 3'(b); m.sr2 = 3'(c); m.imm_sel = ir[5]; m.rw = 1; end
      9:     begin m.dr = 3'(a); m.sr1 = 3'(b); m.rw = 1; end
      0:     m.nzp = 3'(a);
      2, 10: begin m.dr = 3'(a); m.rw = 1; m.mo = 1; end
      14:    begin m.dr = 3'(a); m.rw = 1; end
      3, 11: begin m.sr2 = 3'(a); m.mo = 1; end
      6:     begin m.dr = 3'(a); m.sr1 = 3'(b); m.rw = 1; m.mo = 1; end
      7:     begin m.sr1 = 3'(b); m.sr2 = 3'(a); m.mo = 1; end
      12:    m.sr1 = 3'(b);
      4:     begin m.dr = 3'd7; m.rw = 1; if (ir[11] == 1'b0) m.sr1 = 3'(b); end
      15:    begin m.dr = 3'd7; m.rw = 1; m.mo = 1; end
      default: m.ill = 1;
    endcase
    return m;
  endfunction

  function automatic dec_t observe(input bit sel);
    dec_t o;
    if (sel)
      o = '{i3.ir_out, i3.npc_out, i3.opCode_out, i3.dr_out, i3.sr1_out, i3.sr2_out,
            i3.imm_sel_out, i3.imm5_out, i3.offset6_out, i3.offset9_out, i3.br_nzp_out,
            i3.reg_write_out, i3.mem_op_out, i3.illegal_out};
    else
      o = '{i1.ir_out, i1.npc_out, i1.opCode_out, i1.dr_out, i1.sr1_out, i1.sr2_out,
            i1.imm_sel_out, i1.imm5_out, i1.offset6_out, i1.offset9_out, i1.br_nzp_out,
            i1.reg_write_out, i1.mem_op_out, i1.illegal_out};
    return o;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? i3.decode_done : i1.decode_done;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? i3.busy : i1.busy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input logic start, input logic [15:0] pc,
                        input logic [15:0] instr, input logic fl);
    if (sel) begin
      i3.decode_start = start; i3.pc_in = pc; i3.instr_in = instr; i3.flush = fl;
    end else begin
      i1.decode_start = start; i1.pc_in = pc; i1.instr_in = instr; i1.flush = fl;
    end
  endtask

  // One isolated decode: checks done timing, returns the fields seen while
  // done is high, then lets the DUT fall back to IDLE.
  task automatic txn(input bit sel, input logic [15:0] pc, input logic [15:0] instr,
                     output dec_t got);
    int lat;
    lat = sel ? 3 : 1;
    set_in(sel, 1'b1, pc, instr, 1'b0);
    tick();
    set_in(sel, 1'b0, pc, instr, 1'b0);
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk_bit("done_timing", done_of(sel), (k == lat));
    end
    got = observe(sel);
    tick();
    chk_bit("done_pulse_end", done_of(sel), 1'b0);
  endtask

  vec_t tbl[10];
  dec_t got;

  initial begin
    tbl[0] = '{16'h5260, 16'h3001, dec_t'{16'h5260, 16'h3001, 4'h5, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0000, 16'hFFE0, 9'h060, 3'd0, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{16'h0BFE, 16'h3002, dec_t'{16'h0BFE, 16'h3002, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFE, 16'hFFFE, 9'h1FE, 3'd5, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{16'h6A7F, 16'h3003, dec_t'{16'h6A7F, 16'h3003, 4'h6, 3'd5, 3'd1, 3'd0, 1'b0, 16'hFFFF, 16'hFFFF, 9'h07F, 3'd0, 1'b1, 1'b1, 1'b0}};
    tbl[3] = '{16'hD000, 16'h3004, dec_t'{16'hD000, 16'h3004, 4'hD, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 9'h000, 3'd0, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{16'h8000, 16'h3005, dec_t'{16'h8000, 16'h3005, 4'h8, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 9'h000, 3'd0, 1'b0, 1'b0, 1'b1}};
    tbl[5] = '{16'hF025, 16'h3006, dec_t'{16'hF025, 16'h3006, 4'hF, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0005, 16'hFFE5, 9'h025, 3'd0, 1'b1, 1'b1, 1'b0}};
    tbl[6] = '{16'h4801, 16'h3007, dec_t'{16'h4801, 16'h3007, 4'h4, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0001, 16'h0001, 9'h001, 3'd0, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{16'h4080, 16'h3008, dec_t'{16'h4080, 16'h3008, 4'h4, 3'd7, 3'd2, 3'd0, 1'b0, 16'h0000, 16'h0000, 9'h080, 3'd0, 1'b1, 1'b0, 1'b0}};
    tbl[8] = '{16'h7E42, 16'h3009, dec_t'{16'h7E42, 16'h3009, 4'h7, 3'd0, 3'd1, 3'd7, 1'b0, 16'h0002, 16'h0002, 9'h042, 3'd0, 1'b0, 1'b1, 1'b0}};
    tbl[9] = '{16'h927F, 16'h300A, dec_t'{16'h927F, 16'h300A, 4'h9, 3'd1, 3'd1, 3'd0, 1'b0, 16'hFFFF, 16'hFFFF, 9'h07F, 3'd0, 1'b1, 1'b0, 1'b0}};

    set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;
    repeat (5) tick();
    chk_dec("reset_out_l1", observe(1'b0), '0);
    chk_dec("reset_out_l3", observe(1'b1), '0);
    chk_bit("reset_busy_l1", busy_of(1'b0), 1'b0);
    chk_bit("reset_busy_l3", busy_of(1'b1), 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_bit("idle_done_l1", done_of(1'b0), 1'b0);
      chk_bit("idle_done_l3", done_of(1'b1), 1'b0);
    end

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 10; i++) begin
        txn(s[0], tbl[i].pc, tbl[i].instr, got);
        chk_dec("table", got, tbl[i].exp);
      end

    // Back-to-back: BR, then a start while done is high brings in LDR.
    set_in(1'b0, 1'b1, 16'h3002, 16'h0BFE, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 16'h3002, 16'h0BFE, 1'b0);
    tick();
    chk_bit("b2b_done1", done_of(1'b0), 1'b1);
    chk_dec("b2b_br", observe(1'b0), tbl[1].exp);
    set_in(1'b0, 1'b1, 16'h3003, 16'h6A7F, 1'b0);
    tick();
    chk_bit("b2b_gap_done", done_of(1'b0), 1'b0);
    chk_bit("b2b_gap_busy", busy_of(1'b0), 1'b1);
    set_in(1'b0, 1'b0, 16'h3003, 16'h6A7F, 1'b0);
    tick();
    chk_bit("b2b_done2", done_of(1'b0), 1'b1);
    chk_dec("b2b_ldr", observe(1'b0), tbl[2].exp);
    tick();
    chk_bit("b2b_end", done_of(1'b0), 1'b0);

    // Latency 3: a second start during WAIT must not restart or move npc.
    set_in(1'b1, 1'b1, 16'h4000, 16'h1042, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 16'h5555, 16'h1042, 1'b0);
    tick();
    chk_bit("ign_done_a", done_of(1'b1), 1'b0);
    tick();
    chk_bit("ign_done_b", done_of(1'b1), 1'b0);
    set_in(1'b1, 1'b0, 16'h5555, 16'h1042, 1'b0);
    tick();
    chk_bit("ign_done_c", done_of(1'b1), 1'b1);
    chk_dec("ign_fields", observe(1'b1), model(16'h1042, 16'h4000));
    tick();

    // Flush in the second WAIT cycle: no capture, no done, outputs hold.
    set_in(1'b1, 1'b1, 16'h6000, 16'hF025, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 16'h6000, 16'hF025, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 16'h6000, 16'hF025, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 16'h6000, 16'hF025, 1'b0);
    chk_bit("flush_busy", busy_of(1'b1), 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_bit("flush_no_done", done_of(1'b1), 1'b0);
      tick();
    end
    chk_dec("flush_hold", observe(1'b1), model(16'h1042, 16'h4000));

    // Reset while done is high and a new start is presented.
    set_in(1'b0, 1'b1, 16'h3100, 16'h1042, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 16'h3100, 16'h1042, 1'b0);
    tick();
    chk_bit("rst_pre_done", done_of(1'b0), 1'b1);
    rst = 1'b1;
    set_in(1'b0, 1'b1, 16'h3101, 16'h5260, 1'b0);
    tick();
    chk_dec("rst_out", observe(1'b0), '0);
    chk_bit("rst_busy", busy_of(1'b0), 1'b0);
    chk_bit("rst_done", done_of(1'b0), 1'b0);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 16'h3101, 16'h5260, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bit("rst_after_done", done_of(1'b0), 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] r_ir, r_pc;
      bit sel;
      sel  = (i % 2) == 1;
      r_ir = 16'($urandom);
      r_pc = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      txn(sel, r_pc, r_ir, got);
      chk_dec("random", got, model(r_ir, r_pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
